lfsr_rand_sched: RTL

Round-robin scheduler that shares one 32-bit LFSR random-word source among `NUM_REQ` requesters. It also handles run-time reseeding and a post-seed warm-up phase. Each grant hands the current LFSR state to exactly one requester and advances the generator by one step, so no two consumers ever see the same word. It sits between the free-running random source used across the design and the blocks that consume random words.

---
 rtl/lfsr_rand_pkg.sv | 10 +
 rtl/lfsr_step.sv | 16 +
 rtl/lfsr_rand_sched.sv | 77 +++++++
 3 files changed

// File: rtl/lfsr_rand_pkg.sv
// lfsr_rand_pkg: shared LFSR width, taps, default seed, scheduler states and step function
package lfsr_rand_pkg;
  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] TAP_MASK = 32'h088C_8892;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 32'h00BB_E9F7;
  typedef enum logic {WARMUP, SERVE} state_t;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
  endfunction
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: LFSR state register with load (priority) and step enables
module lfsr_step import lfsr_rand_pkg::*; #(
  parameter logic [LFSR_W-1:0] SEED = 32'h00BB_E9F7
)(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              step_en,
  input  logic              load_en,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state_o
);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state_o <= SEED;
    else if (load_en) state_o <= load_val;
    else if (step_en) state_o <= lfsr_next(state_o);
endmodule

// File: rtl/lfsr_rand_sched.sv
// lfsr_rand_sched: round-robin sharing of one LFSR among requesters; warm-up via LFSR_RAND_SCHED_WARMUP_EN
module lfsr_rand_sched import lfsr_rand_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int WARMUP_CYCLES = 16,
  parameter logic [31:0] SEED_DEFAULT = 32'h00BB_E9F7
)(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               seed_valid_i,
  input  logic [31:0]        seed_i,
  output logic               seed_ready_o,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [31:0]        rand_o,
  output logic               busy_o
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] ptr_q, win, j;
  logic [31:0] lfsr;
  logic serve, seed_acc, grant, found;
`ifdef LFSR_RAND_SCHED_WARMUP_EN
  localparam int CW = WARMUP_CYCLES > 1 ? $clog2(WARMUP_CYCLES) : 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic last;
  assign serve = state_q == SERVE;
  assign last = cnt_q == CW'(WARMUP_CYCLES - 1);
  always_comb state_d = serve ? (seed_acc ? WARMUP : SERVE) : (last ? SERVE : WARMUP);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= WARMUP;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= (serve || last) ? '0 : cnt_q + 1'b1;
    end
`else
  assign serve = 1'b1;
`endif
  assign busy_o = ~serve;
  assign seed_ready_o = serve;
  assign seed_acc = serve & seed_valid_i;
  assign grant = serve & ~seed_valid_i & |req_i;
  // first requester at or after ptr, wrapping
  always_comb begin
    win = '0;
    found = 1'b0;
    j = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_i[j]) begin
        win = j;
        found = 1'b1;
      end
    end
  end
  lfsr_step #(.SEED(SEED_DEFAULT)) u_lfsr (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .step_en(~serve | grant),
    .load_en(seed_acc),
    .load_val(seed_i == '0 ? SEED_DEFAULT : seed_i),
    .state_o(lfsr)
  );
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      gnt_o <= '0;
      rand_o <= '0;
      ptr_q <= '0;
    end else if (grant) begin
      gnt_o <= NUM_REQ'(1) << win;
      rand_o <= lfsr;
      ptr_q <= win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
    end else begin
      gnt_o <= '0;
    end
endmodule
